// File: rtl/imem_fetch_port.sv
// imem_fetch_port: byte-addressed instruction memory with valid/ready fetch and buffered response
module imem_fetch_port #(
  parameter int    MEM_BYTES    = 1024,
  parameter int    PC_WIDTH     = 32,
  parameter int    READ_LATENCY = 1,
  parameter bit    BIG_ENDIAN   = 1,
  parameter string INIT_FILE    = "data.hex"
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [PC_WIDTH-1:0]          req_pc,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_instr,
  output logic [PC_WIDTH-1:0]          rsp_pc,
  output logic [1:0]                   rsp_fault,
  input  logic                         flush,
  input  logic                         prog_we,
  input  logic [$clog2(MEM_BYTES)-1:0] prog_addr,
  input  logic [7:0]                   prog_wdata
);
  localparam int         AW    = $clog2(MEM_BYTES);
  localparam int         L     = READ_LATENCY;
  localparam logic [2:0] DEPTH = 3'(READ_LATENCY + 1);
  localparam logic [1:0] LAST  = 2'(READ_LATENCY);
  logic [7:0]          mem [MEM_BYTES];
  logic                accept, push, pop, misaligned, out_of_range;
  logic [AW-1:0]       addr;
  logic [31:0]         word, load_data;
  logic [1:0]          load_fault;
  logic                pv     [L];
  logic [PC_WIDTH-1:0] ppc    [L];
  logic [1:0]          pfault [L];
  logic [31:0]         pdata  [L];
  logic [PC_WIDTH-1:0] bpc    [4];
  logic [1:0]          bfault [4];
  logic [31:0]         bdata  [4];
  logic [1:0]          wr_ptr, rd_ptr, count;
  logic [2:0]          outstanding;
  always_ff @(posedge clk)
    if (prog_we) mem[prog_addr] <= prog_wdata;
  assign addr = req_pc[AW-1:0];
  always_comb begin
    misaligned   = |req_pc[1:0];
    out_of_range = req_pc > PC_WIDTH'(MEM_BYTES - 4);
    word         = BIG_ENDIAN ? {mem[addr], mem[addr + AW'(1)], mem[addr + AW'(2)], mem[addr + AW'(3)]}
                              : {mem[addr + AW'(3)], mem[addr + AW'(2)], mem[addr + AW'(1)], mem[addr]};
    load_fault   = misaligned ? 2'b01 : out_of_range ? 2'b10 : 2'b00;
    load_data    = (misaligned || out_of_range) ? 32'd0 : word;
  end
  assign rsp_valid = count != 2'd0;
  assign pop       = rsp_valid && rsp_ready;
  assign push      = pv[L-1] && !flush;
  always_comb begin
    outstanding = {1'b0, count};
    for (int i = 0; i < L; i++) outstanding = outstanding + {2'b00, pv[i]};
    req_ready = (outstanding < DEPTH) || (outstanding == DEPTH && pop);
    accept    = req_valid && req_ready && !flush;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < L; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= accept;
      for (int i = 1; i < L; i++) pv[i] <= pv[i-1] && !flush;
    end
  always_ff @(posedge clk) begin
    ppc[0]    <= req_pc;
    pfault[0] <= load_fault;
    pdata[0]  <= load_data;
    for (int i = 1; i < L; i++) begin
      ppc[i]    <= ppc[i-1];
      pfault[i] <= pfault[i-1];
      pdata[i]  <= pdata[i-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
      if (pop) rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  always_ff @(posedge clk)
    if (push) begin
      bpc[wr_ptr]    <= ppc[L-1];
      bfault[wr_ptr] <= pfault[L-1];
      bdata[wr_ptr]  <= pdata[L-1];
    end
  assign rsp_instr = rsp_valid ? bdata[rd_ptr] : 32'd0;
  assign rsp_pc    = rsp_valid ? bpc[rd_ptr] : '0;
  assign rsp_fault = rsp_valid ? bfault[rd_ptr] : 2'b00;
endmodule

// File: tb/tb_imem_fetch_port.sv
// tb_imem_fetch_port: table vectors, corner-case sequences and a randomized queue model
// for a latency-1 big-endian port (a) and a latency-2 little-endian port (b).
module tb_imem_fetch_port;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic       prog_we = 0;
    logic [9:0] prog_addr = 0;
    logic [7:0] prog_wdata = 0;

    logic        a_req_valid = 0, a_req_ready, a_rsp_valid, a_rsp_ready = 1, a_flush = 0;
    logic [31:0] a_req_pc = 0, a_rsp_instr, a_rsp_pc;
    logic [1:0]  a_rsp_fault;
    logic        b_req_valid = 0, b_req_ready, b_rsp_valid, b_rsp_ready = 1, b_flush = 0;
    logic [31:0] b_req_pc = 0, b_rsp_instr, b_rsp_pc;
    logic [1:0]  b_rsp_fault;

    imem_fetch_port #(.MEM_BYTES(1024), .PC_WIDTH(32), .READ_LATENCY(1), .BIG_ENDIAN(1), .INIT_FILE("")) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_pc(a_req_pc),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_instr(a_rsp_instr), .rsp_pc(a_rsp_pc),
        .rsp_fault(a_rsp_fault), .flush(a_flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata));

    imem_fetch_port #(.MEM_BYTES(1024), .PC_WIDTH(32), .READ_LATENCY(2), .BIG_ENDIAN(0), .INIT_FILE("")) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_pc(b_req_pc),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_instr(b_rsp_instr), .rsp_pc(b_rsp_pc),
        .rsp_fault(b_rsp_fault), .flush(b_flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata));

    typedef struct {logic [31:0] pc; logic [31:0] instr; logic [1:0] fault;} vec_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr; logic [1:0] fault; int vis;} exp_t;

    int         tests = 0, fails = 0;
    logic [7:0] mm [1024];
    exp_t       q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] model_fault(input logic [31:0] pc);
        return (pc % 4 != 0) ? 2'b01 : (pc > 1020) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] pc, input bit be);
        if (model_fault(pc) != 2'b00) return 32'd0;
        return be ? {mm[pc], mm[pc+1], mm[pc+2], mm[pc+3]} : {mm[pc+3], mm[pc+2], mm[pc+1], mm[pc]};
    endfunction

    function automatic logic [31:0] pick_pc();
        int r = $urandom % 8;
        if (r == 0) return 32'($urandom_range(1017, 1100));
        if (r == 1) return 32'($urandom_range(0, 127));
        return 32'($urandom_range(0, 31)) * 4;
    endfunction

    task automatic fetch_a(input string nm, input logic [31:0] pc, input logic [31:0] ei, input logic [1:0] ef);
        @(negedge clk);
        a_rsp_ready = 1;
        a_req_valid = 1;
        a_req_pc = pc;
        #1 chk({nm, "_ready"}, 64'(a_req_ready), 64'(1));
        @(negedge clk);
        a_req_valid = 0;
        #1 chk({nm, "_latency"}, 64'(a_rsp_valid), 64'(0));
        @(negedge clk);
        #1 chk({nm, "_rsp"}, 64'({a_rsp_valid, a_rsp_fault, a_rsp_instr}), 64'({1'b1, ef, ei}));
        chk({nm, "_pc"}, 64'(a_rsp_pc), 64'(pc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[10];
        int   n, cyc;
        logic acc, ev, er;
        tv[0] = '{32'd0,          32'h00010203, 2'b00};
        tv[1] = '{32'd4,          32'h04050607, 2'b00};
        tv[2] = '{32'd8,          32'h08090A0B, 2'b00};
        tv[3] = '{32'd6,          32'h0,        2'b01};
        tv[4] = '{32'd1021,       32'h0,        2'b01};
        tv[5] = '{32'd1024,       32'h0,        2'b10};
        tv[6] = '{32'd1020,       32'hFCFDFEFF, 2'b00};
        tv[7] = '{32'd1022,       32'h0,        2'b01};
        tv[8] = '{32'd2000,       32'h0,        2'b10};
        tv[9] = '{32'hFFFF_FFFC,  32'h0,        2'b10};

        #1;
        chk("reset_a", 64'({a_rsp_valid, a_rsp_fault, a_rsp_instr}), 64'(0));
        chk("reset_a_pc", 64'(a_rsp_pc), 64'(0));
        chk("reset_b", 64'({b_rsp_valid, b_rsp_fault, b_rsp_instr}), 64'(0));
        @(negedge clk);
        rst_n = 1;
        #1 chk("ready_after_reset", 64'({a_req_ready, b_req_ready}), 64'(2'b11));

        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            prog_we = 1;
            prog_addr = 10'(i);
            prog_wdata = 8'(i);
            mm[i] = 8'(i);
        end
        @(negedge clk);
        prog_we = 0;

        // Little-endian, latency 2
        @(negedge clk);
        b_req_valid = 1;
        b_req_pc = 4;
        #1 chk("b_le_ready", 64'(b_req_ready), 64'(1));
        @(negedge clk);
        b_req_valid = 0;
        #1 chk("b_le_lat1", 64'(b_rsp_valid), 64'(0));
        @(negedge clk);
        #1 chk("b_le_lat2", 64'(b_rsp_valid), 64'(0));
        @(negedge clk);
        #1 chk("b_le_rsp", 64'({b_rsp_valid, b_rsp_fault, b_rsp_instr}), 64'({1'b1, 2'b00, 32'h07060504}));
        chk("b_le_pc", 64'(b_rsp_pc), 64'(4));
        @(negedge clk);
        #1 chk("b_le_popped", 64'(b_rsp_valid), 64'(0));

        // Backpressure fills exactly DEPTH=3 slots
        n = 0;
        acc = 0;
        b_rsp_ready = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                b_req_valid = 1;
                b_req_pc = 0;
            end else if (acc) b_req_pc = b_req_pc + 4;
            #1 acc = b_req_ready;
            if (acc) n++;
        end
        chk("bp_accepts", 64'(n), 64'(3));
        chk("bp_ready_low", 64'(b_req_ready), 64'(0));
        chk("bp_head", 64'({b_rsp_valid, b_rsp_instr}), 64'({1'b1, 32'h03020100}));
        @(negedge clk);
        #1 chk("bp_hold", 64'({b_rsp_valid, b_rsp_fault, b_rsp_instr}), 64'({1'b1, 2'b00, 32'h03020100}));
        chk("bp_hold_pc", 64'(b_rsp_pc), 64'(0));
        @(negedge clk);
        b_rsp_ready = 1;
        #1 chk("bp_ready_on_pop", 64'(b_req_ready), 64'(1));
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            b_req_valid = 0;
            #1 chk("bp_order", 64'({b_rsp_valid, b_rsp_instr}), 64'({1'b1, model_word(32'(4 * k), 0)}));
            chk("bp_order_pc", 64'(b_rsp_pc), 64'(4 * k));
        end
        @(negedge clk);
        #1 chk("bp_drained", 64'(b_rsp_valid), 64'(0));

        for (int i = 0; i < 10; i++) fetch_a($sformatf("vec%0d", i), tv[i].pc, tv[i].instr, tv[i].fault);

        // Back-to-back throughput
        @(negedge clk);
        a_req_valid = 1;
        a_req_pc = 0;
        @(negedge clk);
        a_req_pc = 4;
        #1 chk("b2b_first_wait", 64'({a_req_ready, a_rsp_valid}), 64'(2'b10));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) a_req_pc = 8;
            else a_req_valid = 0;
            #1 chk("b2b_rsp", 64'({a_rsp_valid, a_rsp_instr}), 64'({1'b1, model_word(32'(4 * k), 1)}));
        end
        @(negedge clk);
        #1 chk("b2b_end", 64'(a_rsp_valid), 64'(0));

        // Flush with a buffered and an in-flight request
        @(negedge clk);
        a_rsp_ready = 0;
        a_req_valid = 1;
        a_req_pc = 0;
        @(negedge clk);
        a_req_pc = 4;
        @(negedge clk);
        a_flush = 1;
        a_req_pc = 12;
        #1 chk("flush_pre", 64'({a_rsp_valid, a_rsp_instr}), 64'({1'b1, 32'h00010203}));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_flush = 0;
            a_req_valid = 0;
            a_rsp_ready = 1;
            #1 chk("flush_empty", 64'(a_rsp_valid), 64'(0));
        end
        fetch_a("flush_next", 8, 32'h08090A0B, 2'b00);

        // Write and read of the same byte on one edge
        @(negedge clk);
        a_req_valid = 1;
        a_req_pc = 8;
        prog_we = 1;
        prog_addr = 8;
        prog_wdata = 8'hAA;
        mm[8] = 8'hAA;
        @(negedge clk);
        a_req_valid = 0;
        prog_we = 0;
        #1 chk("wr_collide_wait", 64'(a_rsp_valid), 64'(0));
        @(negedge clk);
        #1 chk("wr_collide_old", 64'({a_rsp_valid, a_rsp_instr}), 64'({1'b1, 32'h08090A0B}));
        fetch_a("wr_new", 8, 32'hAA090A0B, 2'b00);

        // Randomized traffic against a queue model
        cyc = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            a_req_valid = ($urandom % 4) != 0;
            a_req_pc = pick_pc();
            a_rsp_ready = ($urandom % 3) != 0;
            a_flush = ($urandom % 16) == 0;
            prog_we = ($urandom % 3) == 0;
            prog_addr = 10'($urandom_range(16, 63));
            prog_wdata = 8'($urandom);
            #1;
            ev = q.size() > 0 && q[0].vis <= cyc;
            er = q.size() < 2 || (q.size() == 2 && ev && a_rsp_ready);
            chk("rand_ctl", 64'({a_req_ready, a_rsp_valid}), 64'({er, ev}));
            if (ev) begin
                chk("rand_instr", 64'(a_rsp_instr), 64'(q[0].instr));
                chk("rand_pc_fault", 64'({a_rsp_fault, a_rsp_pc}), 64'({q[0].fault, q[0].pc}));
            end
            @(posedge clk);
            cyc++;
            if (ev && a_rsp_ready) void'(q.pop_front());
            if (a_flush) q.delete();
            else if (a_req_valid && er) q.push_back('{a_req_pc, model_word(a_req_pc, 1), model_fault(a_req_pc), cyc + 1});
            if (prog_we) mm[prog_addr] = prog_wdata;
        end
        @(negedge clk);
        a_req_valid = 0;
        a_flush = 1;
        prog_we = 0;
        @(negedge clk);
        a_flush = 0;

        // Asynchronous reset mid-stream
        @(negedge clk);
        a_rsp_ready = 0;
        a_req_valid = 1;
        a_req_pc = 0;
        @(negedge clk);
        a_req_pc = 4;
        @(negedge clk);
        a_req_valid = 0;
        #1 chk("rst_pre", 64'(a_rsp_valid), 64'(1));
        rst_n = 0;
        #1 chk("rst_async", 64'({a_rsp_valid, a_rsp_fault, a_rsp_instr}), 64'(0));
        chk("rst_async_pc", 64'(a_rsp_pc), 64'(0));
        @(negedge clk);
        rst_n = 1;
        a_rsp_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk("rst_dropped", 64'({a_req_ready, a_rsp_valid}), 64'(2'b10));
        end
        fetch_a("rst_mem_kept", 8, 32'hAA090A0B, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
